// File: rtl/etcpu_mem_pkg.sv
// Shared definitions for the etcpu main-memory responder.
// Holds the clear/idle FSM state type, default geometry and counter width,
// the stored word width (32, or 33 with MAIN_MEM_PARITY_EN defined), and
// the address range check used by the access decode.
package etcpu_mem_pkg;

    localparam int unsigned DEF_DEPTH = 1024;
    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned DATA_W    = 32;

`ifdef MAIN_MEM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } mem_state_e;

    // In range: word aligned and below depth*4 bytes (34-bit compare avoids overflow).
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        logic [33:0] limit;
        limit = 34'(depth) << 2;
        return (addr[1:0] == 2'b00) && (34'(addr) < limit);
    endfunction

endpackage

// File: rtl/main_mem_array.sv
// Word storage for the main-memory responder.
// One synchronous write port and one asynchronous read port.
// Ports:
//   clk      in  clock
//   i_we     in  write enable
//   i_waddr  in  write word index
//   i_wdata  in  write word (WIDTH bits)
//   i_raddr  in  read word index
//   o_rdata  out read word, combinational from the array
module main_mem_array #(
    parameter  int unsigned DEPTH  = 1024,
    parameter  int unsigned WIDTH  = 32,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read port
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/main_mem_resp.sv
// Responder end of the etcpu main-memory interface.
// Word-organised data memory with combinational reads and clocked writes.
// After reset or a clr_req pulse the array is zeroed one word per cycle
// while busy is high; accesses during that time are rejected.
// Optional feature macro: MAIN_MEM_PARITY_EN (stored parity bit, sticky par_err).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   mem_cs       access valid this cycle
//   mem_wen      1 = write, 0 = read
//   mem_addr     byte address (word aligned)
//   mem_dat_in   write data
//   mem_dat_out  read data (0 unless an accepted read)
//   clr_req      pulse to restart the array clear
//   busy         clear in progress
//   rd_cnt       accepted reads, saturating
//   wr_cnt       accepted writes, saturating
//   err_cnt      rejected accesses, saturating
//   par_err      sticky parity error (0 without MAIN_MEM_PARITY_EN)
module main_mem_resp
    import etcpu_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_cs,
    input  logic             mem_wen,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_dat_in,
    output logic [31:0]      mem_dat_out,
    input  logic             clr_req,
    output logic             busy,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             par_err
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nxt;

    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    logic              w_busy;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_idx;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              w_rej;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [WORD_W-1:0] w_wdata;
    logic [WORD_W-1:0] w_wdata_core;
    logic [WORD_W-1:0] w_rword;

    // Address decode and access classification
    assign w_busy     = (r_state == CLEAR);
    assign w_in_range = addr_in_range(mem_addr, DEPTH);
    assign w_idx      = mem_addr[ADDR_W+1:2];
    assign w_rd_ok    = mem_cs & ~mem_wen & ~w_busy & w_in_range;
    assign w_wr_ok    = mem_cs &  mem_wen & ~w_busy & w_in_range;
    assign w_rej      = mem_cs & (w_busy | ~w_in_range);

    // Write arbitration: the clear owns the port while busy; nothing commits on a reset edge
    assign w_we    = rst_n & (w_busy | w_wr_ok);
    assign w_waddr = w_busy ? r_clr_ptr : w_idx;
    assign w_wdata = w_busy ? '0 : w_wdata_core;

    main_mem_array #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_rword)
    );

    assign mem_dat_out = w_rd_ok ? w_rword[DATA_W-1:0] : '0;
    assign busy        = w_busy;
    assign rd_cnt      = r_rd_cnt;
    assign wr_cnt      = r_wr_cnt;
    assign err_cnt     = r_err_cnt;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    // FSM next state: sweep every word once, then wait for clr_req
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            CLEAR: begin
                w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
                if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt   = CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = CLEAR;
                w_clr_ptr_nxt = '0;
            end
        endcase
    end

    // Saturating statistics counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_rd_ok && (r_rd_cnt != CNT_MAX)) begin
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
            if (w_wr_ok && (r_wr_cnt != CNT_MAX)) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
            if (w_rej && (r_err_cnt != CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

`ifdef MAIN_MEM_PARITY_EN
    logic r_par_err;
    logic w_par_bad;

    assign w_wdata_core = {^mem_dat_in, mem_dat_in};
    assign w_par_bad    = w_rd_ok & (w_rword[DATA_W] != ^w_rword[DATA_W-1:0]);

    // Sticky parity flag; entering CLEAR wipes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else if ((r_state == IDLE) && clr_req) begin
            r_par_err <= 1'b0;
        end else if (w_par_bad) begin
            r_par_err <= 1'b1;
        end
    end

    assign par_err = r_par_err;
`else
    assign w_wdata_core = mem_dat_in;
    assign par_err      = 1'b0;
`endif

endmodule

// File: doc/main_mem_resp.md
# main_mem_resp

Responder end of the etcpu main-memory interface: a word-organised data memory that services the core's memory-access stage (chip-select, write-enable, byte address, write data, read data). Reads are combinational from the array so the core can register the result in the same cycle it issues the access; writes commit on the clock edge. After reset, and on request, an internal state machine clears the whole array while holding the interface busy. Access, error and optional parity statistics are exposed for bench and debug use.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two, minimum 4.
- CNT_W, 16: width of the statistics counters.
- clk  in  1  clock; already decided.
- rst_n  in  1  synchronous active-low reset; already decided.
- mem_cs  in  1  chip-select; the access is valid this cycle.
- mem_wen  in  1  write enable (1 = write, 0 = read); meaningful only with mem_cs.
- mem_addr  in  32  byte address; must be word-aligned.
- mem_dat_in  in  32  write data (memory POV input).
- mem_dat_out  out  32  read data (memory POV output).
- clr_req  in  1  single-cycle pulse that restarts the array clear.
- busy  out  1  clear in progress; accesses are ignored.
- rd_cnt  out  CNT_W  accepted reads, saturating.
- wr_cnt  out  CNT_W  accepted writes, saturating.
- err_cnt  out  CNT_W  rejected accesses, saturating.
- par_err  out  1  sticky parity error (see Configuration).

## Operation
- Word index is mem_addr[ADDR_W+1:2], where ADDR_W = $clog2(DEPTH).
- An access is in range when mem_addr < DEPTH*4 and mem_addr[1:0] == 0.
- The FSM has two states:
  - CLEAR: busy=1. Each cycle writes 0 to word clr_ptr, then increments clr_ptr. When clr_ptr == DEPTH-1 is written, the FSM moves to IDLE.
  - IDLE: busy=0. clr_req=1 moves the FSM to CLEAR with clr_ptr=0. clr_req is ignored while in CLEAR.
- Accepted read: mem_cs & !mem_wen & !busy & in range.
  - mem_dat_out = array[index], combinationally. rd_cnt increments by 1.
- Accepted write: mem_cs & mem_wen & !busy & in range.
  - array[index] <= mem_dat_in at the clock edge. wr_cnt increments by 1.
- Rejected access: mem_cs & (busy or not in range).
  - The write is dropped. mem_dat_out = 0. err_cnt increments by 1.
- When mem_cs=0, mem_dat_out = 0.
- All three counters saturate at 2^CNT_W-1. They reset only on rst_n.

## Timing
- Reset (edge with rst_n=0): state=CLEAR, clr_ptr=0, all counters 0, par_err=0.
  - busy=1 and mem_dat_out=0 from that edge on.
  - Array contents are not reset directly; the clear handles them.
- busy stays high for exactly DEPTH cycles after the first edge with rst_n=1. A clr_req accepted in IDLE likewise gives DEPTH busy cycles starting the next cycle.
- Reset asserted mid-clear restarts the clear at clr_ptr=0.
- Read latency is 0 cycles (combinational).
- Write-then-read: a write at edge N is visible to a read in cycle N+1.
- A read of the same word in the same cycle as the write returns the old value; there is no forwarding.
- clr_req in the same cycle as an access: the access completes normally and CLEAR starts on the next cycle.
- Counter increments happen at the clock edge. At saturation the value holds.

## Configuration
- MAIN_MEM_PARITY_EN defined:
  - Each word stores a 33rd bit, ^mem_dat_in, written on every write. The clear stores 0.
  - On an accepted read, a stored bit that differs from ^data sets par_err at the next edge.
  - par_err is cleared by reset or by entering CLEAR.
- MAIN_MEM_PARITY_EN undefined:
  - The array is 32 bits wide.
  - par_err is tied to 0 (the port stays, so benches are unchanged).

## Structure
- Shared package etcpu_mem_pkg holds:
  - the FSM state enum (CLEAR, IDLE);
  - the default DEPTH and CNT_W;
  - an in-range helper function.
- Sub-module main_mem_array holds the storage: one write port and one asynchronous read port, with width 32 or 33 depending on the macro.
- main_mem_resp holds the FSM, address decode, write arbitration (clear vs. core write), counters and parity check.

## Test plan
- Reset, then hold mem_cs=0 -> busy=1 for exactly 1024 cycles, then 0. Read of 0x0 and of 0xFFC returns 0x00000000.
- Write 0xDEADBEEF to 0x10, read 0x10 in the next cycle -> 0xDEADBEEF, wr_cnt=1, rd_cnt=1. A same-cycle read of 0x10 during the write returns the old value.
- Access 0x1000 and 0x12 -> mem_dat_out=0, no array change, err_cnt=2. A read during busy also increments err_cnt.
- After writes, pulse clr_req -> busy for 1024 cycles; all words read 0 afterwards. A reset asserted at clear cycle 500 -> a full 1024-cycle clear restarts.
- Preload rd_cnt near saturation (CNT_W=4): perform 20 reads -> rd_cnt holds at 15.
- With MAIN_MEM_PARITY_EN, flip the stored parity bit of word 3 via hierarchical force, then read 0xC -> par_err=1 next cycle and stays 1 until clr_req.
